// File: rtl/cmd_dispatch_pkg.sv
// Shared opcode, select, error and state encodings for the command dispatch controller.
package cmd_dispatch_pkg;

    localparam logic [7:0] OP_STP = 8'h00;
    localparam logic [7:0] OP_EVP = 8'h01;
    localparam logic [7:0] OP_EVB = 8'h02;
    localparam logic [7:0] OP_RST = 8'h03;

    typedef enum logic [2:0] {
        SEL_STP = 3'd0,
        SEL_EVP = 3'd1,
        SEL_EVB = 3'd2,
        SEL_RST = 3'd3,
        SEL_ERR = 3'd4
    } op_sel_e;

    typedef enum logic [1:0] {
        ERR_NONE   = 2'd0,
        ERR_OPCODE = 2'd1,
        ERR_SLOT   = 2'd2
    } err_code_e;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_WAIT_CMD  = 3'd2,
        ST_DECODE    = 3'd3,
        ST_CHECK     = 3'd4,
        ST_ISSUE     = 3'd5,
        ST_WAIT_EXEC = 3'd6
    } state_e;

    typedef struct packed {
        op_sel_e   sel;
        err_code_e err;
    } decode_t;

    // Occupancy width must match the fetch stage: one extra bit so "full" is representable.
    function automatic int pw_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Invalid opcode takes precedence over an empty-slot evaluation.
    function automatic decode_t decode_cmd(input logic [7:0] instr, input logic slot_ok);
        decode_t d;
        d.sel = SEL_ERR;
        d.err = ERR_OPCODE;
        case (instr)
            OP_STP: begin d.sel = SEL_STP; d.err = ERR_NONE; end
            OP_RST: begin d.sel = SEL_RST; d.err = ERR_NONE; end
            OP_EVP: begin
                d.sel = slot_ok ? SEL_EVP  : SEL_ERR;
                d.err = slot_ok ? ERR_NONE : ERR_SLOT;
            end
            OP_EVB: begin
                d.sel = slot_ok ? SEL_EVB  : SEL_ERR;
                d.err = slot_ok ? ERR_NONE : ERR_SLOT;
            end
            default: begin d.sel = SEL_ERR; d.err = ERR_OPCODE; end
        endcase
        return d;
    endfunction

endpackage

// File: rtl/dispatch_resource_check.sv
// Combinational go/stall decision: does the decoded operation have the FIFO room it needs.
module dispatch_resource_check
    import cmd_dispatch_pkg::*;
#(
    parameter int PW = 11
) (
    input  logic [2:0]    op_sel,
    input  logic [5:0]    op_count,
    input  logic [PW-1:0] data_population,
    input  logic [PW-1:0] result_free,
    output logic          go
);

    logic [PW-1:0] n_ext;

    always_comb begin
        n_ext = PW'(op_count);
        go    = 1'b0;
        case (op_sel_e'(op_sel))
            SEL_STP: go = (data_population >= n_ext);
            SEL_EVP: go = (data_population != '0) && (result_free != '0);
            SEL_EVB: go = (data_population >= n_ext) && (result_free >= n_ext);
            SEL_RST: go = 1'b1;
            SEL_ERR: go = (result_free != '0);
            default: go = 1'b0;
        endcase
    end

endmodule

// File: rtl/cmd_dispatch_fsm.sv
// Fetches one command at a time, decodes it, waits for FIFO resources, issues it and
// tracks which polynomial slots hold valid coefficients.
module cmd_dispatch_fsm
    import cmd_dispatch_pkg::*;
#(
    parameter  int buffer_size = 1024,
    localparam int PW          = pw_width(buffer_size)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [PW-1:0] cmd_population,
    input  logic [PW-1:0] data_population,
    input  logic [PW-1:0] result_free,
    output logic          start_get_cmd,
    input  logic          done_get_cmd,
    input  logic [7:0]    instr,
    input  logic [2:0]    arg1,
    input  logic [4:0]    arg2,
    output logic          start_exec,
    output logic [2:0]    op_sel,
    output logic [2:0]    op_slot,
    output logic [5:0]    op_count,
    output logic [1:0]    err_code,
    input  logic          exec_done,
    output logic [7:0]    slot_valid,
    output logic          busy
);

    state_e     state_reg;
    logic [7:0] instr_reg;
    logic [2:0] arg1_reg;
    logic [4:0] arg2_reg;
    logic       go;
    decode_t    dec;

    assign dec  = decode_cmd(instr_reg, slot_valid[arg1_reg]);
    assign busy = (state_reg != ST_IDLE);

    dispatch_resource_check #(.PW(PW)) u_check (
        .op_sel          (op_sel),
        .op_count        (op_count),
        .data_population (data_population),
        .result_free     (result_free),
        .go              (go)
    );

    // Request pulses are registered, so each appears in the cycle after its state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            start_get_cmd <= 1'b0;
            start_exec    <= 1'b0;
            op_sel        <= '0;
            op_slot       <= '0;
            op_count      <= '0;
            err_code      <= '0;
            slot_valid    <= '0;
            instr_reg     <= '0;
            arg1_reg      <= '0;
            arg2_reg      <= '0;
        end else begin
            start_get_cmd <= 1'b0;
            start_exec    <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (cmd_population != '0)
                        state_reg <= ST_FETCH;
                end
                ST_FETCH: begin
                    start_get_cmd <= 1'b1;
                    state_reg     <= ST_WAIT_CMD;
                end
                ST_WAIT_CMD: begin
                    if (done_get_cmd) begin
                        instr_reg <= instr;
                        arg1_reg  <= arg1;
                        arg2_reg  <= arg2;
                        state_reg <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    op_sel    <= dec.sel;
                    err_code  <= dec.err;
                    op_slot   <= arg1_reg;
                    op_count  <= 6'(arg2_reg) + 6'd1;
                    state_reg <= ST_CHECK;
                end
                ST_CHECK: begin
                    if (go)
                        state_reg <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    start_exec <= 1'b1;
                    state_reg  <= ST_WAIT_EXEC;
                end
                ST_WAIT_EXEC: begin
                    if (exec_done) begin
                        if (op_sel == SEL_STP)
                            slot_valid[op_slot] <= 1'b1;
                        else if (op_sel == SEL_RST)
                            slot_valid[op_slot] <= 1'b0;
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/cmd_dispatch_fsm.md
Name: cmd_dispatch_fsm

Overview:
- Controller directly downstream of the command-fetch/split stage of the polynomial evaluation accelerator.
- Requests one command at a time from the fetch stage and latches the returned instr/arg1/arg2.
- Decodes the command and checks operand/result FIFO occupancy plus a per-slot coefficient-valid table.
- Issues one operation to the execution datapath, waits for its completion, then fetches the next command.

Parameters:
- buffer_size, 1024, depth of the command/data/result FIFOs; occupancy ports are log2(buffer_size)+1 bits wide (call this PW).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- cmd_population  input  PW  entries currently in the command FIFO
- data_population  input  PW  entries currently in the data FIFO
- result_free  input  PW  free entries in the result FIFO
- start_get_cmd  output  1  one-cycle request to the fetch stage
- done_get_cmd  input  1  one-cycle pulse from the fetch stage; instr/arg1/arg2 are valid in that cycle
- instr  input  8  opcode from the fetch stage
- arg1  input  3  polynomial slot index (0..7)
- arg2  input  5  count field; element count N = arg2+1 (1..32)
- start_exec  output  1  one-cycle issue pulse to the datapath
- op_sel  output  3  0 STP, 1 EVP, 2 EVB, 3 RST, 4 ERR; held from ISSUE until exec_done
- op_slot  output  3  latched arg1
- op_count  output  6  latched N
- err_code  output  2  0 none, 1 invalid opcode, 2 empty slot; valid with op_sel=ERR
- exec_done  input  1  one-cycle completion pulse from the datapath
- slot_valid  output  8  slot coefficient-valid bitmap
- busy  output  1  high whenever state is not IDLE

Behaviour:
- Reset (asynchronous, active-high; may arrive mid-operation, including during WAIT_EXEC): state=IDLE; every output 0; slot_valid=0; latched instr/arg registers 0. No completion is pending after reset.
- Opcodes:
  - 8'h00 STP: needs data_population>=N; sets slot on completion.
  - 8'h01 EVP: needs slot valid, data_population>=1, result_free>=1.
  - 8'h02 EVB: needs slot valid, data_population>=N, result_free>=N.
  - 8'h03 RST: no resource need; clears slot on completion.
  - Any other opcode: ERR with err_code=1, needs result_free>=1.
  - EVP or EVB on an invalid slot: ERR with err_code=2, needs result_free>=1.
- Comparisons are unsigned; N is zero-extended to PW bits.
- States:
  - IDLE: go to FETCH when cmd_population!=0.
  - FETCH: start_get_cmd=1 for exactly one cycle; go to WAIT_CMD.
  - WAIT_CMD: on done_get_cmd, latch instr/arg1/arg2 that same edge; go to DECODE.
  - DECODE: one cycle; register op_sel, op_slot, op_count, err_code; go to CHECK.
  - CHECK: stay while resources are insufficient (stall, no timeout); when sufficient go to ISSUE.
  - ISSUE: start_exec=1 for one cycle; go to WAIT_EXEC.
  - WAIT_EXEC: on exec_done apply the slot_valid update (STP set, RST clear, others none) and go to IDLE.
- Minimum cycle from start_get_cmd to start_exec (done_get_cmd returned 3 cycles after start_get_cmd): 7 cycles.
- start_get_cmd and start_exec are never high in the same cycle; at most one command is outstanding.
- done_get_cmd outside WAIT_CMD and exec_done outside WAIT_EXEC are ignored.
- STP on an already-valid slot overwrites; the slot stays valid. RST on an invalid slot is legal and is a no-op for the bitmap.
- Resources are resampled every cycle in CHECK. A condition that becomes true and then false before ISSUE does not issue.

Decomposition:
- Shared package cmd_dispatch_pkg:
  - opcode constants (OP_STP/EVP/EVB/RST)
  - op_sel encodings
  - err_code encodings
  - 3-bit state encodings
  - PW width function (log2 identical to the fetch stage's)
- One natural sub-module: dispatch_resource_check, purely combinational. Inputs: op_sel, op_count, the three populations. Output: the "go" signal.
- slot_valid register and FSM stay in the top module.

Test Plan:
- Reset mid-WAIT_EXEC with slot_valid=8'h05 -> all outputs 0, slot_valid=0, busy=0 the cycle after rst asserts. A later exec_done is ignored.
- cmd_population=1, data_population=4, command STP slot 2 arg2=3 -> op_sel=0, op_slot=2, op_count=4; start_exec 4 cycles after done_get_cmd; after exec_done, slot_valid=8'h04.
- EVB slot 2 arg2=7 with data_population=8 and result_free=5 -> stalls in CHECK, no start_exec. Raise result_free to 8 -> start_exec 2 cycles later with op_count=8.
- EVP on slot 6 with slot_valid=0 -> op_sel=4, err_code=2, issued once result_free>=1.
- instr=8'hFF, arg1=0, arg2=0 -> op_sel=4, err_code=1; slot_valid unchanged.
- RST slot 2 after STP slot 2 -> slot_valid bit 2 cleared on exec_done. A stray done_get_cmd pulse during WAIT_EXEC causes no state change.
